pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer for the MIPS core.
- Sits directly downstream of the next-PC logic: it latches the computed next PC, fetches the instruction at that address from instruction memory over a req/ack handshake, and presents it to decode with a valid/ready handshake.
- It replaces the bare PC flop and lets instruction memory have variable latency.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- npc  in  32  next PC from next-PC logic; sampled only on an advance edge.
- stall  in  1  hazard/control hold; blocks advance while high.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; always equals pc.
- imem_ack  in  1  memory has valid data on imem_rdata this cycle.
- imem_rdata  in  32  instruction word from memory.
- pc  out  32  address of the instruction currently fetched or held.
- instr  out  32  fetched instruction word.
- instr_valid  out  1  instr is valid for decode.
- instr_ready  in  1  decode/execute consumes instr this cycle.
- retired_cnt  out  CNT_W  count of instructions consumed since reset.
- fetch_err  out  1  misaligned fetch trap; exists only with the optional feature, otherwise tied 0.

Behaviour:
- Reset (rst=0, asynchronous, effective immediately, including mid-fetch):
  - pc=RESET_PC; instr=32'h0; instr_valid=0; imem_req=0; retired_cnt=0; fetch_err=0; state=S_BOOT.
- States:
  - S_BOOT: imem_req=0. Next edge -> S_REQ. Gives one idle cycle after reset release.
  - S_REQ: imem_req=1, imem_addr=pc, both held stable until ack.
    - On edge with imem_ack=1: instr<=imem_rdata, instr_valid<=1, -> S_VALID.
    - Otherwise remain in S_REQ; there is no timeout.
  - S_VALID: imem_req=0, instr_valid=1, instr and pc held stable.
    - Advance = instr_ready & ~stall.
    - On an advance edge: pc<=npc, instr_valid<=0, retired_cnt<=retired_cnt+1 (wraps modulo 2^CNT_W), -> S_REQ.
    - instr_ready=1 with stall=1: no advance, nothing changes.
- Ignored inputs:
  - imem_ack outside S_REQ: no effect.
  - npc changing outside an advance edge: no effect.
- Alignment: pc[1:0] is always 2'b00. On load, npc[1:0] is discarded (pc<={npc[31:2],2'b00}).
- Throughput and latency:
  - Minimum 2 cycles per instruction (ack in the first S_REQ cycle, ready in the first S_VALID cycle).
  - Latency from ack to instr_valid is 1 cycle, registered.
- Wrap-around: npc=32'hFFFF_FFFC loads normally; there is no PC overflow check.
- Outputs are registered, except imem_req and imem_addr, which are decoded from state and pc.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - On an advance edge with npc[1:0]!=0: pc<=npc unmodified, fetch_err<=1, -> S_TRAP.
  - S_TRAP: imem_req=0, instr_valid=0; held until reset.
  - retired_cnt still increments for the consumed instruction.
- Undefined: npc[1:0] is silently cleared; fetch_err is constant 0; S_TRAP does not exist.

Test Plan:
- Reset release, imem_ack tied 1, instr_ready=1, npc=pc+4 -> imem_addr sequence 0x3000, 0x3004, 0x3008 at one fetch every 2 cycles; retired_cnt increments 1, 2, 3.
- imem_ack delayed 3 cycles with imem_rdata=0x2408_0005 -> imem_req and imem_addr=0x3000 stable for 4 cycles; instr=0x24080005 with instr_valid=1 on the following cycle.
- In S_VALID, assert stall=1 with instr_ready=1 for 5 cycles while npc toggles -> pc, instr and retired_cnt unchanged; on stall=0, pc loads the current npc.
- Drive rst=0 mid-S_REQ at pc=0x3010 -> same cycle: imem_req=0, pc=0x3000, instr_valid=0, retired_cnt=0.
- Branch: npc=0x0000_3040 on an advance edge -> next imem_addr=0x3040. Wrap: npc=0xFFFF_FFFC -> imem_addr=0xFFFFFFFC.
- npc=0x3006 on an advance edge:
  - Without MISALIGN_TRAP_EN: next imem_addr=0x3004.
  - With MISALIGN_TRAP_EN: fetch_err=1, pc=0x3006, imem_req stays 0 until reset.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//
// Program-counter register and instruction-fetch sequencer. It latches the next
// PC from the next-PC logic, fetches the word at that address from instruction
// memory over a req/ack handshake, and hands it to decode over valid/ready.
// Instruction memory may take any number of cycles to acknowledge.
//
// Configuration macro: MISALIGN_TRAP_EN
//   undefined (default): npc[1:0] is cleared on load, fetch_err is tied 0.
//   defined:             a misaligned npc on an advance edge loads pc unmodified,
//                        raises fetch_err and parks the unit until reset.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   npc          next PC, sampled only on an advance edge
//   stall        hazard/control hold, blocks advance while high
//   imem_req     fetch request to instruction memory
//   imem_addr    fetch address, always equal to pc
//   imem_ack     instruction memory has data on imem_rdata this cycle
//   imem_rdata   instruction word from memory
//   pc           address of the instruction currently fetched or held
//   instr        fetched instruction word
//   instr_valid  instr is valid for decode
//   instr_ready  decode consumes instr this cycle
//   retired_cnt  instructions consumed since reset (wraps)
//   fetch_err    misaligned fetch trap flag

module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      npc,
    input  logic             stall,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      pc,
    output logic [31:0]      instr,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             fetch_err
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_VALID
`ifdef MISALIGN_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    state_t state;
    logic   advance;

    assign advance = instr_ready & ~stall;

    // Request and address are decoded straight from state and pc so memory
    // sees the new address in the same cycle the state enters S_REQ.
    assign imem_req  = (state == S_REQ);
    assign imem_addr = pc;

`ifdef MISALIGN_TRAP_EN
    logic fetch_err_q;
    assign fetch_err = fetch_err_q;
`else
    logic unused_npc_low;
    assign fetch_err      = 1'b0;
    assign unused_npc_low = ^npc[1:0];
`endif

    // Fetch sequencer: boot idle cycle, wait for ack, hold until consumed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_BOOT;
            pc          <= RESET_PC;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            retired_cnt <= '0;
`ifdef MISALIGN_TRAP_EN
            fetch_err_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_BOOT: begin
                    state <= S_REQ;
                end
                S_REQ: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (advance) begin
                        instr_valid <= 1'b0;
                        retired_cnt <= retired_cnt + CNT_W'(1);
`ifdef MISALIGN_TRAP_EN
                        if (npc[1:0] != 2'b00) begin
                            pc          <= npc;
                            fetch_err_q <= 1'b1;
                            state       <= S_TRAP;
                        end else begin
                            pc    <= npc;
                            state <= S_REQ;
                        end
`else
                        pc    <= {npc[31:2], 2'b00};
                        state <= S_REQ;
`endif
                    end
                end
`ifdef MISALIGN_TRAP_EN
                S_TRAP: begin
                    state <= S_TRAP;
                end
`endif
                default: begin
                    state <= S_BOOT;
                end
            endcase
        end
    end

endmodule
